mul_ctrl: RTL
=============

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 80, meaning the maximum number of RUN cycles to wait for mul_op_done (used only when MUL_CTRL_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, operand pair accepted this cycle when in_valid is also high.
REQ-006 SHALL have port in_a, input, 64, signed multiplicand.
REQ-007 SHALL have port in_b, input, 64, signed multiplier.
REQ-008 SHALL have port out_valid, output, 1, result held valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port out_result, output, 128, product.
REQ-011 SHALL have port out_err, output, 1, timeout flag qualifying out_result.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have ports mul_multiplicand and mul_multiplier, outputs, 64 each, operands to the Booth multiplier.
REQ-014 SHALL have ports mul_op_start and mul_op_clear, outputs, 1 each, multiplier controls.
REQ-015 SHALL have ports mul_op_done (input, 1) and mul_result (input, 128), multiplier status and product.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, RUN and RESP.
REQ-017 SHALL hold in_ready at 1 only in IDLE.
REQ-018 In IDLE, in_valid=1 SHALL latch in_a/in_b into operand registers and move to CLEAR.
REQ-019 In CLEAR, mul_op_clear SHALL be 1 for exactly one cycle; mul_op_start SHALL be 0 and mul_op_done SHALL be ignored; next state is RUN.
REQ-020 In RUN, mul_op_start SHALL be held at 1 until mul_op_done is sampled 1, whereupon mul_result is registered into out_result, out_err=0, and the state moves to RESP.
REQ-021 mul_multiplicand/mul_multiplier SHALL be driven from the operand registers and remain stable from CLEAR through RESP.
REQ-022 In RESP, out_valid=1 and out_result/out_err SHALL hold until out_ready=1, then return to IDLE; out_ready already high on entry SHALL complete in that same cycle.
REQ-023 Latency: accept at cycle T, clear at T+1, RUN from T+2, out_valid in the cycle after mul_op_done is first sampled high.
REQ-024 in_valid outside IDLE SHALL be ignored without any state change; no new operand is accepted in the cycle RESP completes.
REQ-025 out_valid SHALL never drop before its handshake; out_result SHALL not change while out_valid=1.

Reset
REQ-026 On reset_n=0, at any time including mid-RUN, SHALL enter IDLE and drive in_ready=1, and drive out_valid, out_err, busy, mul_op_start, mul_op_clear, out_result, mul_multiplicand and mul_multiplier to 0; the watchdog count SHALL reset to 0.

Configuration
REQ-027 With MUL_CTRL_TIMEOUT_EN defined, a RUN-cycle counter SHALL, on reaching TIMEOUT without mul_op_done, force out_result=0 and out_err=1 and move to RESP; mul_op_done in that same cycle takes priority, giving a normal result.
REQ-028 Without MUL_CTRL_TIMEOUT_EN, out_err SHALL be constant 0, no counter SHALL exist, and RUN SHALL wait indefinitely.

Structure
REQ-029 Package mul_pkg SHALL hold the state enum, OP_W=64, RES_W=128 and the TIMEOUT default.
REQ-030 The timeout counter SHALL be sub-module mul_watchdog, instantiated only under MUL_CTRL_TIMEOUT_EN.

Verification
REQ-031 Use a behavioural multiplier model with done 33 cycles after start: 3 x 5 -> out_result=128'd15, out_err=0, out_valid asserted 36 cycles after accept.
REQ-032 Same model: 64'hFFFF_FFFF_FFFF_FFFF x 2 -> out_result=128'hFFFF...FFFE (signed -2), out_err=0.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid while pulsing in_valid with new operands -> result held unchanged, in_ready=0, second pair accepted only after the handshake.
REQ-034 Pull reset_n low for 1 cycle at RUN cycle 10 -> all outputs 0, in_ready=1 next cycle, no out_valid; next transaction 7 x 6 -> 42.
REQ-035 With MUL_CTRL_TIMEOUT_EN and a model that never asserts done -> after 80 RUN cycles out_valid=1, out_err=1, out_result=0; without the macro, out_valid remains 0 for 1000 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg -- shared types and constants for the mul_ctrl slice.
//   OP_W / RES_W  : operand and product widths
//   TIMEOUT_DEF   : default watchdog limit in RUN cycles
//   state_t       : controller states IDLE, CLEAR, RUN, RESP
package mul_pkg;

  localparam int          OP_W        = 64;
  localparam int          RES_W       = 128;
  localparam int unsigned TIMEOUT_DEF = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  // True when the controller can take a new operand pair.
  function automatic logic is_idle(input state_t s);
    return (s == IDLE);
  endfunction

endpackage

// File: rtl/mul_watchdog.sv
// mul_watchdog -- counts consecutive RUN cycles and flags the one in which
// the limit is reached.
//   clk, reset_n : clock, asynchronous active-low reset
//   run          : controller is in RUN this cycle
//   expired      : this is RUN cycle number TIMEOUT
module mul_watchdog
  import mul_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  localparam int unsigned   CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] count;

  // RUN-cycle counter; restarts from zero whenever RUN is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl -- sequences one signed 64x64 multiply on an external Booth
// multiplier: accept operands, clear, run until done, hold the product.
//   clk, reset_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b      : operand handshake (in_ready only in IDLE)
//   out_valid/out_ready/out_result   : product handshake, held until taken
//   out_err                          : result produced by watchdog timeout
//   busy                             : state is not IDLE
//   mul_multiplicand/mul_multiplier  : operand registers to the multiplier
//   mul_op_start/mul_op_clear        : multiplier controls
//   mul_op_done/mul_result           : multiplier status and product
// Optional feature: define MUL_CTRL_TIMEOUT_EN to add the RUN watchdog
// (mul_watchdog, limit TIMEOUT); otherwise RUN waits indefinitely and
// out_err stays 0.
// All outputs are flops loaded from the next-state decode.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_err,
  output logic             busy,
  output logic [OP_W-1:0]  mul_multiplicand,
  output logic [OP_W-1:0]  mul_multiplier,
  output logic             mul_op_start,
  output logic             mul_op_clear,
  input  logic             mul_op_done,
  input  logic [RES_W-1:0] mul_result
);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             timeout;
  logic [RES_W-1:0] result_next;
  logic             err_next;

`ifdef MUL_CTRL_TIMEOUT_EN
  mul_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state == RUN),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, operand capture strobe and next product/error value.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    result_next = out_result;
    err_next    = out_err;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = CLEAR;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        state_next = RUN;
      end
      RUN: begin
        // done wins over a timeout landing in the same cycle
        if (mul_op_done) begin
          state_next  = RESP;
          result_next = mul_result;
          err_next    = 1'b0;
        end else if (timeout) begin
          state_next  = RESP;
          result_next = '0;
          err_next    = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and multiplier control outputs, registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      mul_op_clear <= 1'b0;
      mul_op_start <= 1'b0;
    end else begin
      in_ready     <= is_idle(state_next);
      out_valid    <= (state_next == RESP);
      busy         <= !is_idle(state_next);
      mul_op_clear <= (state_next == CLEAR);
      mul_op_start <= (state_next == RUN);
    end
  end

  // Operand registers: loaded on accept, stable through CLEAR, RUN and RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else if (accept) begin
      mul_multiplicand <= in_a;
      mul_multiplier   <= in_b;
    end else begin
      mul_multiplicand <= mul_multiplicand;
      mul_multiplier   <= mul_multiplier;
    end
  end

  // Product and error flag; only RUN ever changes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_result <= '0;
      out_err    <= 1'b0;
    end else begin
      out_result <= result_next;
      out_err    <= err_next;
    end
  end

endmodule
